// File: rtl/reg_encoder4_2.sv
// Sequential 4-to-2 register-number encoder: latches a register-select mask and
// emits one binary index per set bit, lowest first. Optional ZERO_ERR_EN adds zero_err.
module reg_encoder4_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] reg_no,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] register,
  output logic       out_last
`ifdef ZERO_ERR_EN
  ,
  output logic       zero_err
`endif
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] pend_reg, pend_next;
  logic [3:0] low_onehot;
  logic [1:0] low_idx;
  logic       single_bit;
  logic       in_fire;

  // Isolate the lowest set bit; clearing it retires the index just issued.
  assign low_onehot = pend_reg & (~pend_reg + 4'd1);
  assign single_bit = (pend_reg != 4'd0) && ((pend_reg & (pend_reg - 4'd1)) == 4'd0);

  always_comb begin
    low_idx = 2'd0;
    casez (pend_reg)
      4'b???1: low_idx = 2'd0;
      4'b??10: low_idx = 2'd1;
      4'b?100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  end

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == ISSUE);
  assign register  = out_valid ? low_idx : 2'd0;
  assign out_last  = out_valid && single_bit;
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    case (state_reg)
      IDLE: begin
        if (in_fire && (reg_no != 4'd0)) begin
          pend_next  = reg_no;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          pend_next = pend_reg & ~low_onehot;
          if (single_bit) state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        pend_next  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pend_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
    end
  end

`ifdef ZERO_ERR_EN
  logic zero_err_reg;

  // Pulse for one cycle after an empty mask is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_err_reg <= 1'b0;
    end else begin
      zero_err_reg <= in_fire && (reg_no == 4'd0);
    end
  end

  assign zero_err = zero_err_reg;
`endif

endmodule

// File: tb/tb_reg_encoder4_2.sv
// Directed bench for reg_encoder4_2: a table of per-cycle inputs/expected outputs
// plus a hand-written latency/ordering sequence.
module tb_reg_encoder4_2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] reg_no;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] register;
  logic       out_last;
`ifdef ZERO_ERR_EN
  logic       zero_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_encoder4_2 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .reg_no    (reg_no),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .register  (register),
    .out_last  (out_last)
`ifdef ZERO_ERR_EN
    ,
    .zero_err  (zero_err)
`endif
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] mask;
    logic       ordy;
    logic       exp_ir;
    logic       exp_ov;
    logic [1:0] exp_reg;
    logic       exp_last;
    logic       exp_zerr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int step, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h want %0h", name, step, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         cyc;
  logic [1:0] seen[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; reg_no = 4'd0; out_ready = 1'b0;
    tick();

    //            rst  iv  mask     ordy ir  ov  reg   last zerr
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0}); // reset held
    vecs.push_back('{1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0}); // one-hot accept
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0}); // multi-hot
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0}); // backpressure
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0}); // full mask
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0}); // ignored input
    vecs.push_back('{1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0}); // reset mid-batch
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0}); // zero mask
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      in_valid  = vecs[i].iv;
      reg_no    = vecs[i].mask;
      out_ready = vecs[i].ordy;
      #1;
      check("in_ready",  i, {3'b0, in_ready},  {3'b0, vecs[i].exp_ir});
      check("out_valid", i, {3'b0, out_valid}, {3'b0, vecs[i].exp_ov});
      check("register",  i, {2'b0, register},  {2'b0, vecs[i].exp_reg});
      check("out_last",  i, {3'b0, out_last},  {3'b0, vecs[i].exp_last});
`ifdef ZERO_ERR_EN
      check("zero_err",  i, {3'b0, zero_err},  {3'b0, vecs[i].exp_zerr});
`endif
      $display("step %0d rst=%0b iv=%0b mask=%b ordy=%0b -> ir=%0b ov=%0b reg=%0d last=%0b",
               i, rst, in_valid, reg_no, out_ready, in_ready, out_valid, register, out_last);
      tick();
    end

    // Mask 1001: indices 0 then 3, next in_ready on the third cycle after acceptance.
    rst = 1'b0; in_valid = 1'b1; reg_no = 4'b1001; out_ready = 1'b1;
    #1;
    check("seq_accept_ready", 100, {3'b0, in_ready}, 4'd1);
    tick();
    in_valid = 1'b0; reg_no = 4'd0;
    cyc = 1;
    #1;
    while (!in_ready && cyc <= 20) begin
      if (out_valid) seen.push_back(register);
      tick();
      cyc++;
      #1;
    end
    check("seq_cycles", 101, cyc[3:0], 4'd3);
    check("seq_count", 102, seen.size() > 15 ? 4'hF : seen.size(), 4'd2);
    if (seen.size() == 2) begin
      check("seq_first", 103, {2'b0, seen[0]}, 4'd0);
      check("seq_second", 104, {2'b0, seen[1]}, 4'd3);
    end
    $display("seq mask=1001 cycles=%0d emitted=%0d", cyc, seen.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
